fp_mult_arbiter: RTL
====================

// Module: fp_mult_arbiter
// PURPOSE
// - Shares one floating_point_mult_valid_only instance (in-order, fixed latency, no backpressure) among
//   G_NUM_REQ requesters; sits between the polynomial/filter engines and the single FP32 multiplier.
// - Round-robin grant, in-order tag FIFO routes each product back to its requester's result FIFO;
//   credit check guarantees no result is ever dropped.
// PARAMETERS
// - G_NUM_REQ      4   number of requesters (2..8)
// - G_FIFO_DEPTH   4   per-requester result FIFO depth (power of 2, >=2)
// - G_MAX_INFLIGHT 16  tag FIFO depth; must be >= multiplier latency + 1 (power of 2)
// PORTS
// - clk            in   1               clock
// - reset_n        in   1               synchronous reset, active low
// - enable         in   1               0 = stop granting, drain, then idle
// - req_din1       in   32*G_NUM_REQ    operand A, requester i at [32*i+:32]
// - req_din2       in   32*G_NUM_REQ    operand B
// - req_valid      in   G_NUM_REQ       operand pair valid
// - req_ready      out  G_NUM_REQ       one-hot grant; transfer when valid&ready
// - rsp_dout       out  32*G_NUM_REQ    product, head of result FIFO i
// - rsp_valid      out  G_NUM_REQ       result FIFO i non-empty
// - rsp_ready      in   G_NUM_REQ       pop result FIFO i
// - busy           out  1               any product in flight or any result FIFO non-empty
// BEHAVIOUR
// - Clock clk, reset reset_n: synchronous, active low. During reset all outputs 0: req_ready=0, rsp_valid=0,
//   rsp_dout=0, busy=0; FIFOs, credits, RR pointer (->0) cleared; state=SM_INIT.
// - States: SM_INIT -(1 cycle)-> SM_RUN; SM_RUN -(enable=0)-> SM_DRAIN; SM_DRAIN -(tag FIFO empty)-> SM_IDLE;
//   SM_IDLE -(enable=1)-> SM_RUN. SM_INIT with enable=0 goes to SM_IDLE.
// - Grants only in SM_RUN. Eligible(i) = req_valid[i] & (fifo_cnt[i]+inflight[i] < G_FIFO_DEPTH) & tag FIFO not full.
// - req_ready is combinational one-hot: first eligible index at or after rr_ptr (wrapping mod G_NUM_REQ).
//   On transfer: mult din_valid=1 same cycle with that requester's operands, push tag i, inflight[i]++,
//   rr_ptr <= i+1 (wrap G_NUM_REQ-1 -> 0). No transfer: rr_ptr unchanged. Max one issue per cycle.
// - Mult dout_valid: pop tag t, write dout into result FIFO t, inflight[t]--. Same-cycle issue and
//   return on one requester: inflight net unchanged. Same-cycle write and rsp pop on FIFO t: count unchanged.
// - Result FIFO: first-word-fall-through; rsp_dout/rsp_valid registered from FIFO head; empty -> rsp_valid=0.
//   Credit check makes overflow impossible; a write to a full FIFO is a design error (assertion).
// - Latency: issue to rsp_valid = multiplier latency + 1 cycle. Per-requester order preserved.
// - dout_valid with empty tag FIFO: error, assertion fires, result dropped.
// - enable=0 mid-operation: no new grants; in-flight products still land in FIFOs; rsp side keeps draining
//   in all states. reset_n=0 mid-operation: in-flight products discarded (tag FIFO cleared; any later
//   dout_valid with empty tag FIFO after reset is ignored, not asserted, for G_MAX_INFLIGHT cycles).
// - busy = (tag FIFO non-empty) | (|rsp_valid).
// - Arithmetic: counters width $clog2(G_FIFO_DEPTH)+1; no FP manipulation in this block.
// CONFIGURATION
// - FP_MULT_ARB_STATS_EN defined: adds outputs stat_grants [31:0] (total transfers) and
//   stat_stalls [31:0] (cycles in SM_RUN with |req_valid and no grant); both saturate at 0xFFFFFFFF,
//   clear on reset. Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Single req0: A=0x3F800000 (1.0), B=0x40000000 (2.0) -> rsp_dout[0]=0x40000000 after latency+1 cycles.
// - All 4 valid continuously, rsp_ready=all 1 -> grants 0,1,2,3,0,... one per cycle; each gets own products.
// - req1 rsp_ready=0, 6 requests -> 4 grants (G_FIFO_DEPTH) then req_ready[1]=0; other reqs still granted.
// - 3.0*0.5 (0x40400000*0x3F000000) on req2 with enable dropped next cycle -> result 0x3FC00000 delivered,
//   state SM_DRAIN -> SM_IDLE, no further grants, busy=0 after pop.
// - reset_n=0 with 5 in flight -> outputs 0 next cycle, no rsp_valid afterwards, rr_ptr=0.
// - STATS_EN: 10 grants plus 3 stall cycles -> stat_grants=10, stat_stalls=3.

Source files
------------

// File: rtl/fp_mult_arbiter.sv
// Round-robin share of one fixed-latency FP32 multiplier among G_NUM_REQ requesters, with per-requester result FIFOs.
// Latency: issue to rsp_valid = multiplier latency + 1; credits stop grants before a result FIFO could overflow.
// Optional FP_MULT_ARB_STATS_EN adds saturating grant/stall counters.

module fp_mult_arb_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_vld,
  input  logic [W-1:0]         wr_dat,
  input  logic                 rd_rdy,
  output logic [W-1:0]         rd_dat,
  output logic                 rd_vld,
  output logic [$clog2(D):0]   cnt
);
  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [D];
  logic [W-1:0]  mem_d [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, do_wr, do_rd;

  always_comb begin
    full     = (cnt_q == CW'(D));
    do_rd    = rd_rdy && (cnt_q != '0);
    do_wr    = wr_vld && (!full || do_rd);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign rd_vld = (cnt_q != '0);
  assign cnt    = cnt_q;

  assert property (@(posedge clk) disable iff (!reset_n) !(wr_vld && full && !rd_rdy));
endmodule

// FP32 multiplier: round-to-nearest-even, subnormals flushed to zero, single quiet NaN.
// Fixed latency G_LAT cycles, accepts one operand pair per cycle, no backpressure.
module floating_point_mult_valid_only #(
  parameter int G_LAT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        din_valid,
  output logic [31:0] dout,
  output logic        dout_valid
);
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic [9:0]  exp_u;
  logic        sign, grd, stk;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0] res;
  logic [31:0] dat_q [G_LAT];
  logic [31:0] dat_d [G_LAT];
  logic [G_LAT-1:0] vld_q, vld_d;

  always_comb begin
    ea     = din1[30:23];
    eb     = din2[30:23];
    ma     = {1'b1, din1[22:0]};
    mb     = {1'b1, din2[22:0]};
    sign   = din1[31] ^ din2[31];
    prod   = {24'd0, ma} * {24'd0, mb};
    // product of two [1,2) mantissas lies in [1,4): bit 47 selects the normalising shift
    if (prod[47]) begin
      mant = prod[46:24];
      grd  = prod[23];
      stk  = |prod[22:0];
    end else begin
      mant = prod[45:23];
      grd  = prod[22];
      stk  = |prod[21:0];
    end
    mant_r = {1'b0, mant} + {23'd0, grd & (stk | mant[0])};
    exp_u  = {2'b0, ea} + {2'b0, eb} + {9'd0, prod[47]} + {9'd0, mant_r[23]};
    a_nan  = (ea == 8'hFF) && (din1[22:0] != '0);
    b_nan  = (eb == 8'hFF) && (din2[22:0] != '0);
    a_inf  = (ea == 8'hFF) && (din1[22:0] == '0);
    b_inf  = (eb == 8'hFF) && (din2[22:0] == '0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = 32'h7FC0_0000;
    else if (a_inf || b_inf)    res = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)  res = {sign, 31'd0};
    else if (exp_u >= 10'd382)  res = {sign, 8'hFF, 23'd0};
    else if (exp_u <= 10'd127)  res = {sign, 31'd0};
    else                        res = {sign, 8'(exp_u - 10'd127), mant_r[22:0]};
  end

  always_comb begin
    dat_d[0] = res;
    vld_d[0] = din_valid;
    for (int s = 1; s < G_LAT; s++) begin
      dat_d[s] = dat_q[s-1];
      vld_d[s] = vld_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) vld_q <= '0;
    else          vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign dout       = dat_q[G_LAT-1];
  assign dout_valid = vld_q[G_LAT-1];
endmodule

module fp_mult_arbiter #(
  parameter int G_NUM_REQ      = 4,
  parameter int G_FIFO_DEPTH   = 4,
  parameter int G_MAX_INFLIGHT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [32*G_NUM_REQ-1:0] req_din1,
  input  logic [32*G_NUM_REQ-1:0] req_din2,
  input  logic [G_NUM_REQ-1:0]    req_valid,
  output logic [G_NUM_REQ-1:0]    req_ready,
  output logic [32*G_NUM_REQ-1:0] rsp_dout,
  output logic [G_NUM_REQ-1:0]    rsp_valid,
  input  logic [G_NUM_REQ-1:0]    rsp_ready,
  output logic                    busy
`ifdef FP_MULT_ARB_STATS_EN
  ,
  output logic [31:0]             stat_grants,
  output logic [31:0]             stat_stalls
`endif
);
  localparam int MULT_LAT = 3;
  localparam int PW   = $clog2(G_NUM_REQ);
  localparam int CW   = $clog2(G_FIFO_DEPTH) + 1;
  localparam int TCW  = $clog2(G_MAX_INFLIGHT) + 1;

  typedef enum logic [1:0] {SM_INIT, SM_RUN, SM_DRAIN, SM_IDLE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        inflight_q [G_NUM_REQ];
  logic [CW-1:0]        inflight_d [G_NUM_REQ];
  logic [TCW-1:0]       ign_cnt_q, ign_cnt_d;
  logic [CW-1:0]        fifo_cnt [G_NUM_REQ];
  logic [31:0]          head [G_NUM_REQ];
  logic [G_NUM_REQ-1:0] elig, grant, ret;
  logic [PW-1:0]        grant_idx;
  logic                 found;
  logic [31:0]          mult_din1, mult_din2, mult_dout;
  logic                 mult_dout_vld;
  logic [PW-1:0]        tag_dat;
  logic                 tag_vld, tag_full;
  logic [TCW-1:0]       tag_cnt;

  always_comb begin
    int idx;
    idx       = 0;
    tag_full  = (tag_cnt == TCW'(G_MAX_INFLIGHT));
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < G_NUM_REQ; i++) begin
      elig[i] = reset_n && (state_q == SM_RUN) && req_valid[i] && !tag_full &&
                (({1'b0, fifo_cnt[i]} + {1'b0, inflight_q[i]}) < (CW+1)'(G_FIFO_DEPTH));
    end
    for (int k = 0; k < G_NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= G_NUM_REQ) idx = idx - G_NUM_REQ;
      if (!found && elig[idx]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
    mult_din1 = req_din1[32*grant_idx +: 32];
    mult_din2 = req_din2[32*grant_idx +: 32];
  end

  always_comb begin
    for (int i = 0; i < G_NUM_REQ; i++) begin
      ret[i]        = mult_dout_vld && tag_vld && (tag_dat == PW'(i));
      inflight_d[i] = inflight_q[i] + CW'(grant[i]) - CW'(ret[i]);
      rsp_dout[32*i +: 32] = rsp_valid[i] ? head[i] : 32'd0;
    end
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (grant_idx == PW'(G_NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    ign_cnt_d = (ign_cnt_q != '0) ? ign_cnt_q - 1'b1 : ign_cnt_q;
    state_d = state_q;
    case (state_q)
      SM_INIT:  state_d = enable ? SM_RUN : SM_IDLE;
      SM_RUN:   if (!enable) state_d = SM_DRAIN;
      SM_DRAIN: if (!tag_vld) state_d = SM_IDLE;
      SM_IDLE:  if (enable) state_d = SM_RUN;
      default:  state_d = SM_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= SM_INIT;
      rr_ptr_q   <= '0;
      inflight_q <= '{default: '0};
      ign_cnt_q  <= TCW'(G_MAX_INFLIGHT);
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      ign_cnt_q  <= ign_cnt_d;
    end
  end

  assign req_ready = grant;
  assign busy      = tag_vld | (|rsp_valid);

  floating_point_mult_valid_only #(.G_LAT(MULT_LAT)) u_mult (
    .clk        (clk),
    .reset_n    (reset_n),
    .din1       (mult_din1),
    .din2       (mult_din2),
    .din_valid  (found),
    .dout       (mult_dout),
    .dout_valid (mult_dout_vld)
  );

  // tags leave in issue order, matching the multiplier's in-order pipeline
  fp_mult_arb_fifo #(.W(PW), .D(G_MAX_INFLIGHT)) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (found),
    .wr_dat  (grant_idx),
    .rd_rdy  (mult_dout_vld),
    .rd_dat  (tag_dat),
    .rd_vld  (tag_vld),
    .cnt     (tag_cnt)
  );

  for (genvar g = 0; g < G_NUM_REQ; g++) begin : g_rsp
    fp_mult_arb_fifo #(.W(32), .D(G_FIFO_DEPTH)) u_rsp_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_vld  (ret[g]),
      .wr_dat  (mult_dout),
      .rd_rdy  (rsp_ready[g]),
      .rd_dat  (head[g]),
      .rd_vld  (rsp_valid[g]),
      .cnt     (fifo_cnt[g])
    );
  end

  // stray products from before a reset are dropped silently during the ignore window
  assert property (@(posedge clk) disable iff (!reset_n)
    !(mult_dout_vld && !tag_vld && (ign_cnt_q == '0)));

`ifdef FP_MULT_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d, stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stalls_d = stat_stalls_q;
    if (found && (stat_grants_q != 32'hFFFF_FFFF)) stat_grants_d = stat_grants_q + 1'b1;
    if ((state_q == SM_RUN) && (|req_valid) && !found && (stat_stalls_q != 32'hFFFF_FFFF))
      stat_stalls_d = stat_stalls_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`endif
endmodule
